reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order queue that tracks every dispatched instruction from rename/dispatch until commit.
//  Sits beside the reservation stations: dispatch allocates an entry here and forwards the index as rob_entry to the RS.
//  The CDB marks entries done, possibly out of order. Entries retire strictly in program order to the RRAT/free list.
// PARAMETERS
//  ROB_DEPTH    16  number of entries; power of 2, >= 2; ROB_IDX_W = $clog2(ROB_DEPTH)
//  ARCH_REG_W    5  architectural register index width
//  PHYS_REG_W    6  physical register index width
// PORTS
//  clk                 in   1           clock, all state updates on rising edge
//  rst                 in   1           reset, asynchronous, active-low (0 = reset)
//  dispatch_valid      in   1           dispatch requests allocation this cycle
//  dispatch_rd         in   ARCH_REG_W  arch destination of dispatched instr
//  dispatch_pd         in   PHYS_REG_W  phys destination from free list
//  dispatch_ready      out  1           ROB can accept an allocation (not full)
//  dispatch_rob_entry  out  ROB_IDX_W   index allocated this cycle (= tail)
//  cdb_valid           in   1           CDB broadcasting a completed instr
//  cdb_rob_entry       in   ROB_IDX_W   ROB index of completed instr
//  commit_valid        out  1           head entry retiring this cycle
//  commit_rd           out  ARCH_REG_W  arch reg of retiring entry
//  commit_pd           out  PHYS_REG_W  phys reg of retiring entry
//  commit_rob_entry    out  ROB_IDX_W   index of retiring entry
//  num_entries         out  ROB_IDX_W+1 occupied entry count, 0..ROB_DEPTH
// BEHAVIOUR
//  - State
//    - head/tail pointers of ROB_IDX_W+1 bits; MSB is the wrap bit.
//    - Per entry: valid, done, rd, pd.
//  - Empty/full
//    - empty: head == tail.
//    - full: low bits equal and wrap bits differ.
//  - Reset (rst low, async)
//    - head = tail = 0; all valid/done cleared.
//    - Outputs: dispatch_ready=1, dispatch_rob_entry=0, commit_valid=0, commit_*=0, num_entries=0.
//    - Asserting rst mid-operation discards all entries immediately, without waiting for a clock edge.
//  - Dispatch
//    - dispatch_ready = ~full, combinational. It does NOT account for a same-cycle commit.
//    - dispatch_rob_entry = tail[ROB_IDX_W-1:0], combinational, valid in the same cycle as the request.
//    - On an edge with dispatch_valid && dispatch_ready: entry[tail] <= {valid=1, done=0, rd, pd}; tail++.
//    - dispatch_valid while full: ignored, no state change.
//  - CDB
//    - On an edge with cdb_valid && entry[cdb_rob_entry].valid: done <= 1.
//    - cdb_valid to an invalid entry: ignored.
//    - Completion to commit is 1 cycle min: done registers at edge N, commit_valid rises after edge N.
//  - Commit (combinational outputs, at most 1 per cycle)
//    - commit_valid = ~empty && entry[head].done.
//    - commit_rd/pd/rob_entry come from entry[head] when commit_valid=1, otherwise 0.
//    - On an edge with commit_valid: entry[head].valid/done <= 0; head++.
//    - Commit is never back-pressured.
//  - Simultaneous events
//    - Dispatch + commit in one cycle: both occur; num_entries unchanged.
//    - CDB targeting the head entry in the same cycle it commits: the CDB write is dropped (entry is freed).
//  - Pointer arithmetic wraps modulo 2*ROB_DEPTH.
//  - num_entries = tail - head (ROB_IDX_W+1 bit subtraction).
// TESTING
//  1. Reset: drive rst=0 between edges -> outputs take reset values immediately; rst=1 -> dispatch_ready=1, num_entries=0.
//  2. Fill: 16 dispatches with rd=i, pd=32+i -> dispatch_rob_entry 0..15, num_entries=16, dispatch_ready=0;
//     a 17th dispatch_valid is ignored (tail and count unchanged).
//  3. Out-of-order completion: CDB entries 2, then 1, then 0 on successive cycles ->
//     no commit until entry 0 is done, then commits of 0, 1, 2 (pd=32, 33, 34) on 3 consecutive cycles.
//  4. Wrap-around: after 16 allocs/commits the next dispatch gets entry 0 and the tail wrap bit toggles;
//     full/empty stay correct across 3 wraps.
//  5. Simultaneous events: count=5 with head done, plus dispatch and CDB(entry 3) in one cycle ->
//     commit occurs, num_entries stays 5, entry 3 done next cycle.
//  6. CDB to invalid entry: empty ROB, cdb_valid with entry 7 -> no state change;
//     a later allocation of entry 7 has done=0.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB and commit signals shared between the rename/dispatch side and the reorder buffer.
// The master side issues dispatch and CDB traffic; the slave side is the reorder buffer.
interface reorder_buffer_if #(
  parameter int ROB_DEPTH  = 16,
  parameter int ARCH_REG_W = 5,
  parameter int PHYS_REG_W = 6
);
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  logic                  dispatch_valid;
  logic [ARCH_REG_W-1:0] dispatch_rd;
  logic [PHYS_REG_W-1:0] dispatch_pd;
  logic                  dispatch_ready;
  logic [ROB_IDX_W-1:0]  dispatch_rob_entry;
  logic                  cdb_valid;
  logic [ROB_IDX_W-1:0]  cdb_rob_entry;
  logic                  commit_valid;
  logic [ARCH_REG_W-1:0] commit_rd;
  logic [PHYS_REG_W-1:0] commit_pd;
  logic [ROB_IDX_W-1:0]  commit_rob_entry;
  logic [ROB_IDX_W:0]    num_entries;

  modport master (
    output dispatch_valid, dispatch_rd, dispatch_pd, cdb_valid, cdb_rob_entry,
    input  dispatch_ready, dispatch_rob_entry, commit_valid, commit_rd, commit_pd,
           commit_rob_entry, num_entries
  );

  modport slave (
    input  dispatch_valid, dispatch_rd, dispatch_pd, cdb_valid, cdb_rob_entry,
    output dispatch_ready, dispatch_rob_entry, commit_valid, commit_rd, commit_pd,
           commit_rob_entry, num_entries
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at dispatch, marks done from the CDB out of order,
// and retires at most one entry per cycle strictly in program order.
module reorder_buffer #(
  parameter int ROB_DEPTH  = 16,
  parameter int ARCH_REG_W = 5,
  parameter int PHYS_REG_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  reorder_buffer_if.slave rob
);
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam logic [ROB_IDX_W:0] PTR_ONE = {{ROB_IDX_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ROB_IDX_W:0]    head_r;
  logic [ROB_IDX_W:0]    tail_r;
  logic [ROB_DEPTH-1:0]  valid_r;
  logic [ROB_DEPTH-1:0]  done_r;
  logic [ARCH_REG_W-1:0] rd_r [ROB_DEPTH];
  logic [PHYS_REG_W-1:0] pd_r [ROB_DEPTH];

  logic [ROB_IDX_W-1:0]  head_idx_s;
  logic [ROB_IDX_W-1:0]  tail_idx_s;
  logic [ROB_IDX_W-1:0]  cdb_idx_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  commit_s;
  logic                  dispatch_s;
  logic                  cdb_s;

  // Occupancy decode and per-cycle event qualification.
  always_comb begin
    head_idx_s = head_r[ROB_IDX_W-1:0];
    tail_idx_s = tail_r[ROB_IDX_W-1:0];
    cdb_idx_s  = rob.cdb_rob_entry;
    empty_s    = (head_r == tail_r);
    full_s     = (head_idx_s == tail_idx_s) && (head_r[ROB_IDX_W] != tail_r[ROB_IDX_W]);
    commit_s   = !empty_s && done_r[head_idx_s];
    dispatch_s = rob.dispatch_valid && !full_s;
    // A completion aimed at the entry retiring this cycle is dropped: the slot is being freed.
    cdb_s      = rob.cdb_valid && valid_r[cdb_idx_s] && !(commit_s && (cdb_idx_s == head_idx_s));
  end

  // Combinational output drive; commit fields are zeroed when nothing retires.
  always_comb begin
    rob.dispatch_ready     = !full_s;
    rob.dispatch_rob_entry = tail_idx_s;
    rob.num_entries        = tail_r - head_r;
    rob.commit_valid       = commit_s;
    if (commit_s) begin
      rob.commit_rd        = rd_r[head_idx_s];
      rob.commit_pd        = pd_r[head_idx_s];
      rob.commit_rob_entry = head_idx_s;
    end else begin
      rob.commit_rd        = '0;
      rob.commit_pd        = '0;
      rob.commit_rob_entry = '0;
    end
  end

  // Entry state and pointer update on each rising edge, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      valid_r <= '0;
      done_r  <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_r[i] <= '0;
        pd_r[i] <= '0;
      end
    end else begin
      if (cdb_s) begin
        done_r[cdb_idx_s] <= 1'b1;
      end
      if (commit_s) begin
        valid_r[head_idx_s] <= 1'b0;
        done_r[head_idx_s]  <= 1'b0;
        head_r              <= head_r + PTR_ONE;
      end
      // The tail slot is never valid when dispatch fires, so it cannot collide with a CDB write.
      if (dispatch_s) begin
        valid_r[tail_idx_s] <= 1'b1;
        done_r[tail_idx_s]  <= 1'b0;
        rd_r[tail_idx_s]    <= rob.dispatch_rd;
        pd_r[tail_idx_s]    <= rob.dispatch_pd;
        tail_r              <= tail_r + PTR_ONE;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer with a queue-based program-order model
// and a scoreboard monitor that checks every cycle's outputs.
module tb_reorder_buffer;
  localparam int DEPTH = 16;

  typedef struct {
    int idx;
    int rd;
    int pd;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_DEPTH(DEPTH), .ARCH_REG_W(5), .PHYS_REG_W(6)) bus ();
  reorder_buffer #(.ROB_DEPTH(DEPTH), .ARCH_REG_W(5), .PHYS_REG_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .rob(bus)
  );

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   model_q[$];
  bit   done_m[DEPTH];
  int   alloc = 0;
  rec_t sb_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_commit();
    return (model_q.size() > 0) && done_m[model_q[0]];
  endfunction

  task automatic model_clear();
    model_q.delete();
    sb_q.delete();
    foreach (done_m[i]) done_m[i] = 1'b0;
    alloc = 0;
  endtask

  // Program-order model: entries retire from the front once done; the head is freed before a same-cycle CDB lands.
  task automatic model_step();
    bit com;
    bit full;
    bit inq;
    int ce;
    if (!rst) return;
    com  = exp_commit();
    full = (model_q.size() == DEPTH);
    ce   = int'(bus.cdb_rob_entry);
    inq  = 1'b0;
    for (int i = 0; i < model_q.size(); i++) if (model_q[i] == ce) inq = 1'b1;
    if (bus.cdb_valid && inq && !(com && ce == model_q[0])) done_m[ce] = 1'b1;
    if (com) begin
      done_m[model_q[0]] = 1'b0;
      void'(model_q.pop_front());
    end
    if (bus.dispatch_valid && !full) begin
      rec_t r;
      r.idx = alloc % DEPTH;
      r.rd  = int'(bus.dispatch_rd);
      r.pd  = int'(bus.dispatch_pd);
      model_q.push_back(r.idx);
      done_m[r.idx] = 1'b0;
      sb_q.push_back(r);
      alloc++;
    end
  endtask

  task automatic cycle(input bit dv, input int rd, input int pd, input bit cv, input int ce);
    bus.dispatch_valid = dv;
    bus.dispatch_rd    = 5'(rd);
    bus.dispatch_pd    = 6'(pd);
    bus.cdb_valid      = cv;
    bus.cdb_rob_entry  = 4'(ce);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && model_q.size() > 0; n++) cycle(1'b0, 0, 0, 1'b1, model_q[0]);
    cycle(1'b0, 0, 0, 1'b0, 0);
    chk("drain_empty", int'(bus.num_entries), 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, int'(bus.dispatch_ready), 1);
    chk({nm, "_entry"}, int'(bus.dispatch_rob_entry), 0);
    chk({nm, "_cvalid"}, int'(bus.commit_valid), 0);
    chk({nm, "_crd"}, int'(bus.commit_rd), 0);
    chk({nm, "_cpd"}, int'(bus.commit_pd), 0);
    chk({nm, "_cidx"}, int'(bus.commit_rob_entry), 0);
    chk({nm, "_count"}, int'(bus.num_entries), 0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      chk("ready", int'(bus.dispatch_ready), int'(model_q.size() < DEPTH));
      chk("alloc_idx", int'(bus.dispatch_rob_entry), alloc % DEPTH);
      chk("count", int'(bus.num_entries), model_q.size());
      chk("commit_valid", int'(bus.commit_valid), int'(exp_commit()));
      if (bus.commit_valid) begin
        if (sb_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL commit_unexpected: got commit of entry %0d expected none", bus.commit_rob_entry);
        end else begin
          rec_t r;
          r = sb_q.pop_front();
          chk("commit_idx", int'(bus.commit_rob_entry), r.idx);
          chk("commit_rd", int'(bus.commit_rd), r.rd);
          chk("commit_pd", int'(bus.commit_pd), r.pd);
        end
      end else begin
        chk("idle_rd", int'(bus.commit_rd), 0);
        chk("idle_pd", int'(bus.commit_pd), 0);
        chk("idle_idx", int'(bus.commit_rob_entry), 0);
      end
    end
  end

  initial begin
    int base;
    bus.dispatch_valid = 1'b0;
    bus.dispatch_rd    = '0;
    bus.dispatch_pd    = '0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_rob_entry  = '0;
    model_clear();
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Fill to capacity, then one more request that must be ignored.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, i, 32 + i, 1'b0, 0);
    chk("full_count", int'(bus.num_entries), DEPTH);
    chk("full_ready", int'(bus.dispatch_ready), 0);
    cycle(1'b1, 31, 63, 1'b0, 0);
    chk("overfill_count", int'(bus.num_entries), DEPTH);
    chk("overfill_tail", int'(bus.dispatch_rob_entry), 0);

    // Out-of-order completion 2, 1, 0: nothing retires until entry 0 is done.
    cycle(1'b0, 0, 0, 1'b1, 2);
    chk("ooo_no_commit_a", int'(bus.commit_valid), 0);
    cycle(1'b0, 0, 0, 1'b1, 1);
    chk("ooo_no_commit_b", int'(bus.commit_valid), 0);
    cycle(1'b0, 0, 0, 1'b1, 0);
    chk("ooo_commit0_pd", int'(bus.commit_pd), 32);
    cycle(1'b0, 0, 0, 1'b0, 0);
    chk("ooo_commit1_pd", int'(bus.commit_pd), 33);
    cycle(1'b0, 0, 0, 1'b0, 0);
    chk("ooo_commit2_pd", int'(bus.commit_pd), 34);
    cycle(1'b0, 0, 0, 1'b0, 0);
    drain();

    // After one full lap the next allocation must land on entry 0 again.
    chk("wrap_entry0", int'(bus.dispatch_rob_entry), 0);

    // Dispatch + commit + CDB in one cycle keeps the count at 5.
    base = alloc % DEPTH;
    for (int i = 0; i < 4; i++) cycle(1'b1, i, 40 + i, 1'b0, 0);
    cycle(1'b1, 4, 44, 1'b1, base);
    chk("simul_pre_count", int'(bus.num_entries), 5);
    chk("simul_pre_commit", int'(bus.commit_valid), 1);
    cycle(1'b1, 5, 45, 1'b1, (base + 3) % DEPTH);
    chk("simul_post_count", int'(bus.num_entries), 5);
    drain();

    // CDB to an empty slot 7 must not leave it done for its later allocation.
    while (alloc % DEPTH != 7) begin
      cycle(1'b1, 1, 1, 1'b0, 0);
      drain();
    end
    cycle(1'b0, 0, 0, 1'b1, 7);
    chk("inv_cdb_count", int'(bus.num_entries), 0);
    cycle(1'b1, 9, 19, 1'b0, 0);
    cycle(1'b0, 0, 0, 1'b0, 0);
    cycle(1'b0, 0, 0, 1'b0, 0);
    chk("inv_cdb_not_done", int'(bus.commit_valid), 0);
    drain();

    // Random traffic, many wraps.
    for (int n = 0; n < 1200; n++) begin
      bit dv;
      bit cv;
      int ce;
      dv = ($urandom_range(0, 99) < 55);
      cv = ($urandom_range(0, 99) < 75);
      if (model_q.size() > 0 && $urandom_range(0, 99) < 85)
        ce = model_q[$urandom_range(0, model_q.size() - 1)];
      else
        ce = $urandom_range(0, DEPTH - 1);
      cycle(dv, $urandom_range(0, 31), $urandom_range(0, 63), cv, ce);
    end

    // Asynchronous reset between edges with entries outstanding.
    for (int i = 0; i < 6; i++) cycle(1'b1, i, i, 1'b0, 0);
    chk("pre_reset_nonempty", int'(bus.num_entries != 0), 1);
    bus.dispatch_valid = 1'b0;
    bus.cdb_valid      = 1'b0;
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    chk_reset_outputs("async_rst");
    cycle(1'b1, 3, 3, 1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rel_ready", int'(bus.dispatch_ready), 1);
    chk("rel_count", int'(bus.num_entries), 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, i, 50 + i, 1'b1, i);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
